sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 11 +
 rtl/sync_fifo_ram.sv | 26 ++
 rtl/sync_fifo.sv | 119 +++++++++++
 tb/tb_sync_fifo.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helper for the sync_fifo elastic buffer.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: synchronous write port, asynchronous read port.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Contents survive reset; only the pointers in the parent are cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with empty/full throttling.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic                  deq,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CW-1:0]         count_r, count_nxt_s;
  logic                  empty_s, full_s, push_s, pop_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == CW'(DEPTH));

  // Handshake resolution: a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    pop_s        = deq & ~empty_s;
    push_s       = enq & (~full_s | pop_s);
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + AW'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (data_in),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Stale memory is masked so an empty FIFO always shows zeros.
  always_comb begin
    if (empty_s) begin
      data_out = {DATA_WIDTH{1'b0}};
    end else begin
      data_out = rdata_s;
    end
  end

  assign empty = empty_s;
  assign full  = full_s;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_r, underflow_r;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (enq && !push_s) begin
        overflow_r <= 1'b1;
      end
      if (deq && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every negedge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq = 1'b0;
  logic          deq = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          empty, full;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow, underflow;
  bit            m_ovf, m_unf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq[$];
  bit            m_pop, m_push;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .enq      (enq),
    .deq      (deq),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  // Reference model: a plain queue updated with the FIFO's acceptance rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
`ifdef SYNC_FIFO_ERR_EN
      m_ovf = 1'b0;
      m_unf = 1'b0;
`endif
    end else begin
      m_pop  = deq && (mq.size() > 0);
      m_push = enq && ((mq.size() < DEPTH) || m_pop);
`ifdef SYNC_FIFO_ERR_EN
      if (enq && !m_push) m_ovf = 1'b1;
      if (deq && mq.size() == 0) m_unf = 1'b1;
`endif
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(data_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    chk("model_empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    chk("model_full",  {31'd0, full},  {31'd0, mq.size() == DEPTH});
    chk("model_data",  {24'd0, data_out}, (mq.size() == 0) ? 32'd0 : {24'd0, mq[0]});
`ifdef SYNC_FIFO_ERR_EN
    chk("model_ovf", {31'd0, overflow},  {31'd0, m_ovf});
    chk("model_unf", {31'd0, underflow}, {31'd0, m_unf});
`endif
  end

  task automatic drive(input bit e, input bit d, input logic [DW-1:0] din);
    enq = e; deq = d; data_in = din;
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [DW-1:0] exp);
    chk(name, {24'd0, data_out}, {24'd0, exp});
    drive(1'b0, 1'b1, 8'h00);
  endtask

  logic [DW-1:0] init_vals [8] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
  logic [DW-1:0] alt_vals  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    #2;
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full",  {31'd0, full},  32'd0);
    chk("reset_data",  {24'd0, data_out}, 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("reset_ovf", {31'd0, overflow},  32'd0);
    chk("reset_unf", {31'd0, underflow}, 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Push 8, pop 4.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, init_vals[i]);
    for (int i = 0; i < 4; i++) pop_expect("first_pops", init_vals[i]);
    chk("four_left_empty", {31'd0, empty}, 32'd0);
    chk("four_left_size", mq.size(), 32'd4);

    // Alternate push/pop.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, alt_vals[i]);
      pop_expect("alt_pops", init_vals[4 + i]);
    end
    chk("alt_size", mq.size(), 32'd4);

    // Drain, then underflow attempt.
    for (int i = 0; i < 4; i++) pop_expect("drain_pops", alt_vals[i]);
    chk("drained_empty", {31'd0, empty}, 32'd1);
    drive(1'b0, 1'b1, 8'h00);
    chk("extra_deq_empty", {31'd0, empty}, 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    chk("underflow_set", {31'd0, underflow}, 32'd1);
`endif
    drive(1'b1, 1'b0, 8'h5A);
    pop_expect("after_underflow", 8'h5A);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(i));
    chk("filled_full", {31'd0, full}, 32'd1);
    drive(1'b1, 1'b0, 8'hFF);
    chk("drop_full", {31'd0, full}, 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    chk("overflow_set", {31'd0, overflow}, 32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) pop_expect("full_drain", DW'(i));
    chk("full_drain_empty", {31'd0, empty}, 32'd1);

    // Simultaneous push/pop while full.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(i));
    chk("simul_head", {24'd0, data_out}, 32'h00);
    drive(1'b1, 1'b1, 8'h77);
    chk("simul_full", {31'd0, full}, 32'd1);
    for (int i = 1; i < DEPTH; i++) pop_expect("simul_drain", DW'(i));
    pop_expect("simul_last", 8'h77);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h30 + i));
    enq = 1'b1; data_in = 8'h99;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_empty", {31'd0, empty}, 32'd1);
    chk("async_rst_full",  {31'd0, full},  32'd0);
    chk("async_rst_data",  {24'd0, data_out}, 32'd0);
    enq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic with phase-varying push/pop bias.
    for (int ph = 0; ph < 8; ph++) begin
      int pe, pd;
      pe = (ph % 2 == 0) ? 75 : 30;
      pd = (ph % 2 == 0) ? 30 : 75;
      for (int c = 0; c < 400; c++) begin
        drive($urandom_range(0, 99) < pe, $urandom_range(0, 99) < pd, DW'($urandom));
      end
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
